// File: rtl/pair_pack_tx_16.sv
// Packs pairs of samples into one AXI4-Stream beat (earlier sample in the low half).
// Define PAIR_PACK_FORCE_LAST_EN to force last on the max_len-th sample and expose overflow_o.
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_LOW  | no half held; next sample is low half or an odd tail
// ST_HIGH | low half held in low_q; next sample completes the beat
module pair_pack_tx_16 #(
   parameter int unsigned          data_size = 16,
   parameter logic [data_size-1:0] pad_value = '0,
   parameter int unsigned          max_len   = 255
) (
   input  logic                   axi_clock_i,
   input  logic                   axi_reset_n_i,
   input  logic                   sample_valid_i,
   input  logic [data_size-1:0]   sample_data_i,
   input  logic                   sample_last_i,
   output logic                   sample_ready_o,
   input  logic                   m_axis_ready_i,
   output logic                   m_axis_valid_o,
   output logic [2*data_size-1:0] m_axis_data_o,
   output logic                   m_axis_last_o,
   output logic [7:0]             vector_len_o,
`ifdef PAIR_PACK_FORCE_LAST_EN
   output logic                   overflow_o,
`endif
   output logic                   vector_done_o
);

   localparam logic [7:0] MAX_LEN_C = 8'(max_len);

   typedef enum logic {ST_LOW, ST_HIGH} state_t;

   state_t                 state_q, state_d;
   logic [data_size-1:0]   low_q, low_d;
   logic                   valid_q, valid_d;
   logic [2*data_size-1:0] data_q, data_d;
   logic                   last_q, last_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [7:0]             pend_len_q, pend_len_d;
   logic [7:0]             len_q, len_d;
   logic                   done_q, done_d;
   logic                   run_q;
`ifdef PAIR_PACK_FORCE_LAST_EN
   logic                   ovf_q, ovf_d;
`endif

   logic       force_last;
   logic       eff_last;
   logic       stall;
   logic       ready;
   logic       accept;
   logic       xfer;
   logic [7:0] cnt_inc;

   always_comb begin
      force_last = 1'b0;
`ifdef PAIR_PACK_FORCE_LAST_EN
      force_last = (cnt_q == MAX_LEN_C - 8'd1);
`endif
      eff_last = sample_last_i || force_last;
      stall    = valid_q && !m_axis_ready_i;

      // An odd tail in LOW needs the output register, so it waits like HIGH does.
      if (!run_q)                ready = 1'b0;
      else if (state_q == ST_HIGH) ready = !stall;
      else                       ready = !(eff_last && stall);

      accept  = sample_valid_i && ready;
      xfer    = valid_q && m_axis_ready_i;
      cnt_inc = (cnt_q == MAX_LEN_C) ? cnt_q : cnt_q + 8'd1;

      state_d    = state_q;
      low_d      = low_q;
      valid_d    = valid_q;
      data_d     = data_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      pend_len_d = pend_len_q;
      len_d      = len_q;
      done_d     = 1'b0;
`ifdef PAIR_PACK_FORCE_LAST_EN
      ovf_d      = ovf_q;
`endif

      if (xfer) begin
         valid_d = 1'b0;
         if (last_q) begin
            len_d  = pend_len_q;
            done_d = 1'b1;
         end
      end

      if (accept) begin
         if (state_q == ST_HIGH) begin
            data_d  = {sample_data_i, low_q};
            last_d  = eff_last;
            valid_d = 1'b1;
            state_d = ST_LOW;
         end else if (eff_last) begin
            data_d  = {pad_value, sample_data_i};
            last_d  = 1'b1;
            valid_d = 1'b1;
         end else begin
            low_d   = sample_data_i;
            state_d = ST_HIGH;
         end

         // Length is captured at load time and published when the last beat leaves.
         if (eff_last) begin
            cnt_d      = 8'd0;
            pend_len_d = cnt_inc;
         end else begin
            cnt_d = cnt_inc;
         end
`ifdef PAIR_PACK_FORCE_LAST_EN
         if (force_last && !sample_last_i) ovf_d = 1'b1;
`endif
      end
   end

   always_ff @(posedge axi_clock_i or negedge axi_reset_n_i) begin
      if (!axi_reset_n_i) begin
         state_q    <= ST_LOW;
         low_q      <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         last_q     <= 1'b0;
         cnt_q      <= 8'd0;
         pend_len_q <= 8'd0;
         len_q      <= 8'd0;
         done_q     <= 1'b0;
         run_q      <= 1'b0;
`ifdef PAIR_PACK_FORCE_LAST_EN
         ovf_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         low_q      <= low_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         pend_len_q <= pend_len_d;
         len_q      <= len_d;
         done_q     <= done_d;
         run_q      <= 1'b1;
`ifdef PAIR_PACK_FORCE_LAST_EN
         ovf_q      <= ovf_d;
`endif
      end
   end

   assign sample_ready_o = ready;
   assign m_axis_valid_o = valid_q;
   assign m_axis_data_o  = data_q;
   assign m_axis_last_o  = last_q;
   assign vector_len_o   = len_q;
   assign vector_done_o  = done_q;
`ifdef PAIR_PACK_FORCE_LAST_EN
   assign overflow_o     = ovf_q;
`endif

endmodule

// File: tb/tb_pair_pack_tx_16.sv
// Directed bench for pair_pack_tx_16: beat packing, odd tails, backpressure, reset and max length.
// Build with PAIR_PACK_FORCE_LAST_EN defined to exercise the forced-last variant.
module tb_pair_pack_tx_16;

   logic        clk_sys = 1'b0;
   logic        rst_b   = 1'b1;
   logic        sample_valid_i = 1'b0;
   logic [15:0] sample_data_i  = '0;
   logic        sample_last_i  = 1'b0;
   logic        sample_ready_o;
   logic        m_axis_ready_i = 1'b1;
   logic        m_axis_valid_o;
   logic [31:0] m_axis_data_o;
   logic        m_axis_last_o;
   logic [7:0]  vector_len_o;
   logic        vector_done_o;
`ifdef PAIR_PACK_FORCE_LAST_EN
   logic        overflow_o;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] beat_data_q[$];
   logic        beat_last_q[$];
   int          done_cnt = 0;

   pair_pack_tx_16 dut (
      .axi_clock_i   (clk_sys),
      .axi_reset_n_i (rst_b),
      .sample_valid_i(sample_valid_i),
      .sample_data_i (sample_data_i),
      .sample_last_i (sample_last_i),
      .sample_ready_o(sample_ready_o),
      .m_axis_ready_i(m_axis_ready_i),
      .m_axis_valid_o(m_axis_valid_o),
      .m_axis_data_o (m_axis_data_o),
      .m_axis_last_o (m_axis_last_o),
      .vector_len_o  (vector_len_o),
`ifdef PAIR_PACK_FORCE_LAST_EN
      .overflow_o    (overflow_o),
`endif
      .vector_done_o (vector_done_o)
   );

   always #5 clk_sys = ~clk_sys;

   // A handshake seen at the negedge completes at the following posedge.
   always @(negedge clk_sys) begin
      if (rst_b) begin
         if (m_axis_valid_o && m_axis_ready_i) begin
            beat_data_q.push_back(m_axis_data_o);
            beat_last_q.push_back(m_axis_last_o);
         end
         if (vector_done_o) done_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic send_sample(input logic [15:0] d, input logic l);
      int n = 0;
      sample_valid_i = 1'b1;
      sample_data_i  = d;
      sample_last_i  = l;
      @(negedge clk_sys);
      while (!sample_ready_o && n < 50) begin
         n++;
         @(negedge clk_sys);
      end
      if (!sample_ready_o) chk("send_timeout", sample_ready_o, 1);
      @(posedge clk_sys); #1;
      sample_valid_i = 1'b0;
      sample_last_i  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (m_axis_valid_o && n < 50) begin
         n++;
         @(posedge clk_sys); #1;
      end
      if (m_axis_valid_o) chk("drain_timeout", m_axis_valid_o, 0);
      repeat (2) @(posedge clk_sys);
      #1;
   endtask

   task automatic expect_beat(input string tag, input logic [31:0] d, input logic l);
      chk({tag, "_present"}, beat_data_q.size() != 0, 1);
      if (beat_data_q.size() != 0) begin
         chk({tag, "_data"}, beat_data_q.pop_front(), d);
         chk({tag, "_last"}, beat_last_q.pop_front(), l);
      end
   endtask

   initial begin
      int done0;
      #1 rst_b = 1'b0;
      #2;
      chk("rst_valid", m_axis_valid_o, 0);
      chk("rst_data",  m_axis_data_o,  0);
      chk("rst_last",  m_axis_last_o,  0);
      chk("rst_len",   vector_len_o,   0);
      chk("rst_done",  vector_done_o,  0);
      chk("rst_ready", sample_ready_o, 0);
`ifdef PAIR_PACK_FORCE_LAST_EN
      chk("rst_ovf",   overflow_o,     0);
`endif
      repeat (2) @(posedge clk_sys);
      #1 rst_b = 1'b1;
      @(posedge clk_sys); #1;

      // four samples, even length
      done0 = done_cnt;
      send_sample(16'h0001, 0);
      send_sample(16'h0002, 0);
      send_sample(16'h0003, 0);
      send_sample(16'h0004, 1);
      drain();
      expect_beat("v4_b0", 32'h0002_0001, 0);
      expect_beat("v4_b1", 32'h0004_0003, 1);
      chk("v4_len",  vector_len_o, 4);
      chk("v4_done", done_cnt - done0, 1);

      // three samples, odd tail padded
      done0 = done_cnt;
      send_sample(16'h1111, 0);
      send_sample(16'h2222, 0);
      send_sample(16'h3333, 1);
      drain();
      expect_beat("v3_b0", 32'h2222_1111, 0);
      expect_beat("v3_b1", 32'h0000_3333, 1);
      chk("v3_len",  vector_len_o, 3);
      chk("v3_done", done_cnt - done0, 1);

      // single sample, beat valid one cycle after accept
      send_sample(16'hABCD, 1);
      chk("v1_lat_valid", m_axis_valid_o, 1);
      chk("v1_lat_data",  m_axis_data_o,  32'h0000_ABCD);
      chk("v1_lat_last",  m_axis_last_o,  1);
      drain();
      expect_beat("v1_b0", 32'h0000_ABCD, 1);
      chk("v1_len", vector_len_o, 1);

      // eight samples with a five-cycle downstream stall after the first beat
      done0 = done_cnt;
      send_sample(16'h0010, 0);
      send_sample(16'h0011, 0);
      m_axis_ready_i = 1'b0;
      fork
         begin
            for (int i = 2; i < 8; i++) send_sample(16'(16'h0010 + i), i == 7);
         end
         begin
            logic [31:0] held;
            held = m_axis_data_o;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk_sys);
               chk("stall_valid", m_axis_valid_o, 1);
               chk("stall_data",  m_axis_data_o,  held);
            end
            chk("stall_ready_high", sample_ready_o, 0);
            @(posedge clk_sys); #1;
            m_axis_ready_i = 1'b1;
         end
      join
      drain();
      expect_beat("bp_b0", 32'h0011_0010, 0);
      expect_beat("bp_b1", 32'h0013_0012, 0);
      expect_beat("bp_b2", 32'h0015_0014, 0);
      expect_beat("bp_b3", 32'h0017_0016, 1);
      chk("bp_extra", beat_data_q.size(), 0);
      chk("bp_len",   vector_len_o, 8);
      chk("bp_done",  done_cnt - done0, 1);

      // reset while holding a low half
      send_sample(16'h5555, 0);
      rst_b = 1'b0;
      #1;
      chk("mid_rst_valid", m_axis_valid_o, 0);
      chk("mid_rst_data",  m_axis_data_o,  0);
      chk("mid_rst_len",   vector_len_o,   0);
      chk("mid_rst_ready", sample_ready_o, 0);
      @(posedge clk_sys); #1;
      rst_b = 1'b1;
      @(posedge clk_sys); #1;
      send_sample(16'h0007, 1);
      drain();
      expect_beat("post_rst_b0", 32'h0000_0007, 1);
      chk("post_rst_extra", beat_data_q.size(), 0);
      chk("post_rst_len",   vector_len_o, 1);

      // long vector past max_len
      done0 = done_cnt;
`ifdef PAIR_PACK_FORCE_LAST_EN
      for (int i = 1; i <= 256; i++) send_sample(16'(i), 0);
`else
      for (int i = 1; i <= 256; i++) send_sample(16'(i), i == 256);
`endif
      drain();
      for (int k = 1; k <= 127; k++)
         expect_beat("long_pair", {16'(2 * k), 16'(2 * k - 1)}, 0);
`ifdef PAIR_PACK_FORCE_LAST_EN
      expect_beat("long_b128", 32'h0000_00FF, 1);
      chk("long_ovf",  overflow_o, 1);
      chk("long_len",  vector_len_o, 255);
      chk("long_done", done_cnt - done0, 1);
      send_sample(16'h0101, 1);
      drain();
      expect_beat("after_ovf_b0", 32'h0101_0100, 1);
      chk("after_ovf_len", vector_len_o, 2);
      chk("after_ovf_sticky", overflow_o, 1);
`else
      expect_beat("long_b128", 32'h0100_00FF, 1);
      chk("long_len",  vector_len_o, 255);
      chk("long_done", done_cnt - done0, 1);
`endif
      chk("final_extra", beat_data_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
